// File: rtl/mem_wb_skid_if.sv
// MEM->WB stage bus: MEM-side capture signals, WB-side delivery signals and both handshakes.
// master = the surrounding pipeline (MEM producer plus WB consumer); slave = the stage itself.
interface mem_wb_skid_if #(
  parameter int D_WIDTH = 32,
  parameter int RF_SIZE = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [D_WIDTH-1:0] alu_out_mem;
  logic [D_WIDTH-1:0] r_data_mem;
  logic [RF_SIZE-1:0] rd_mem;
  logic               reg_write_mem;
  logic               mem_to_reg_mem;
  logic [2:0]         load_fmt_mem;

  logic               out_valid;
  logic               out_ready;
  logic [D_WIDTH-1:0] alu_out_wb;
  logic [D_WIDTH-1:0] mem_data_wb;
  logic [D_WIDTH-1:0] wb_data_wb;
  logic [RF_SIZE-1:0] rd_wb;
  logic               reg_write_wb;
  logic               mem_to_reg_wb;

  modport master (
    output in_valid, alu_out_mem, r_data_mem, rd_mem, reg_write_mem,
           mem_to_reg_mem, load_fmt_mem, out_ready,
    input  in_ready, out_valid, alu_out_wb, mem_data_wb, wb_data_wb,
           rd_wb, reg_write_wb, mem_to_reg_wb
  );

  modport slave (
    input  in_valid, alu_out_mem, r_data_mem, rd_mem, reg_write_mem,
           mem_to_reg_mem, load_fmt_mem, out_ready,
    output in_ready, out_valid, alu_out_wb, mem_data_wb, wb_data_wb,
           rd_wb, reg_write_wb, mem_to_reg_wb
  );
endinterface

// File: rtl/mem_wb_skid.sv
// MEM->WB pipeline register with a 2-entry skid buffer (MAIN drives WB, SKID absorbs
// the entry that arrives while WB stalls). Load data is formatted as it is captured.
module mem_wb_skid #(
  parameter int D_WIDTH = 32,
  parameter int RF_SIZE = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  mem_wb_skid_if.slave  bus
);

  typedef enum logic [2:0] {
    FMT_LB  = 3'd0,
    FMT_LH  = 3'd1,
    FMT_LW  = 3'd2,
    FMT_LBU = 3'd4,
    FMT_LHU = 3'd5
  } load_fmt_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [D_WIDTH-1:0] alu_out;
    logic [D_WIDTH-1:0] mem_data;
    logic [RF_SIZE-1:0] rd;
    logic               reg_write;
    logic               mem_to_reg;
  } entry_t;

  // Lane selection works on the low word only; a misaligned halfword still
  // uses lane addr[1] and never traps.
  function automatic logic [D_WIDTH-1:0] format_load(
    input logic [2:0]         fmt,
    input logic [1:0]         lane,
    input logic [D_WIDTH-1:0] word
  );
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (fmt)
      FMT_LB:  return {{(D_WIDTH-8){byte_sel[7]}}, byte_sel};
      FMT_LH:  return {{(D_WIDTH-16){half_sel[15]}}, half_sel};
      FMT_LBU: return {{(D_WIDTH-8){1'b0}}, byte_sel};
      FMT_LHU: return {{(D_WIDTH-16){1'b0}}, half_sel};
      default: return word;
    endcase
  endfunction

  state_e state, state_next;
  logic   in_ready_q;
  entry_t main_q, skid_q, in_entry;
  logic   out_valid;
  logic   accept, consume;
  logic   load_main_in, load_main_skid, load_skid;

  assign in_entry = '{
    alu_out:    bus.alu_out_mem,
    mem_data:   format_load(bus.load_fmt_mem, bus.alu_out_mem[1:0], bus.r_data_mem),
    rd:         bus.rd_mem,
    reg_write:  bus.reg_write_mem,
    mem_to_reg: bus.mem_to_reg_mem
  };

  assign out_valid = (state != EMPTY);
  assign accept    = bus.in_valid & in_ready_q;
  assign consume   = out_valid & bus.out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch.
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_next   = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          case ({accept, consume})
            2'b10: begin
              state_next = FULL;
              load_skid  = 1'b1;
            end
            2'b01:   state_next   = EMPTY;
            2'b11:   load_main_in = 1'b1;
            default: ;
          endcase
        end
        FULL: begin
          if (consume) begin
            state_next     = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // in_ready comes straight from a flop: it is low in FULL, so no accept can
  // ever race a full buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the entry registers are reset because they drive the WB outputs, which must read zero in reset.
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_entry;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid;
  assign bus.alu_out_wb    = main_q.alu_out;
  assign bus.mem_data_wb   = main_q.mem_data;
  assign bus.wb_data_wb    = main_q.mem_to_reg ? main_q.mem_data : main_q.alu_out;
  assign bus.rd_wb         = main_q.rd;
  assign bus.mem_to_reg_wb = main_q.mem_to_reg;
  assign bus.reg_write_wb  = out_valid & main_q.reg_write & (|main_q.rd);

endmodule
